// File: rtl/fir_pkg.sv
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Shared sample type, width constant and saturation helper for
//             the fir_cascade / fir_decimator pair.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Clamp a wide signed value into the 16-bit sample range.
    function automatic sample_t sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return sample_t'(x[SAMPLE_W-1:0]);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sync_fifo.sv
// ============================================================================
//  Module   : fir_sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO; push and pop may
//             coincide at any occupancy, including full.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];

    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_decimator.sv
// ============================================================================
//  Module   : fir_decimator
//  Brief    : Joins the validity/data token channels, averages every DECIM
//             flagged samples into a rounded 16-bit result and buffers it.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_decimator
    import fir_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid_valid,
    input  logic                       i_valid_data,
    output logic                       i_valid_stop,
    input  logic                       i_data_valid,
    input  logic signed [SAMPLE_W-1:0] i_data_data,
    output logic                       i_data_stop,
    output logic                       o_valid_valid,
    output logic                       o_valid_data,
    input  logic                       o_valid_stop,
    output logic                       o_data_valid,
    output logic signed [SAMPLE_W-1:0] o_data_data,
    input  logic                       o_data_stop
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int ACC_W = SAMPLE_W + SHIFT;
    localparam int SUM_W = ACC_W + 1;
    localparam int PH_W  = (SHIFT > 0) ? SHIFT : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic signed [ACC_W-1:0]    r_acc;
    logic [PH_W-1:0]            r_phase;
    logic                       r_res_vld;
    sample_t                    r_res;

    logic                       w_accept;
    logic                       w_full_pend;
    logic [CNT_W:0]             w_pend_cnt;
    logic                       w_last;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    w_shift;
    sample_t                    w_res;
    logic                       w_pop;
    logic [SAMPLE_W-1:0]        w_head;
    logic [CNT_W-1:0]           w_fifo_count;
    logic                       w_fifo_empty;
    logic                       w_fifo_full;

    // The in-flight result register counts as an occupied slot, so the stop
    // path back to the input never depends combinationally on the output stops.
    assign w_pend_cnt  = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_res_vld};
    assign w_full_pend = w_fifo_full | (w_pend_cnt >= (CNT_W+1)'(FIFO_DEPTH));

    assign w_accept     = ~reset & i_valid_valid & i_data_valid & ~w_full_pend;
    assign i_valid_stop = ~w_accept;
    assign i_data_stop  = ~w_accept;

    assign w_last  = (r_phase == PH_W'(DECIM - 1));
    assign w_sum   = SUM_W'(r_acc) + SUM_W'(i_data_data) + SUM_W'(DECIM / 2);
    assign w_shift = w_sum >>> SHIFT;
    assign w_res   = sat16(32'(w_shift));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_phase   <= '0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
        end else begin
            r_res_vld <= 1'b0;
            if (w_accept && i_valid_data) begin
                if (w_last) begin
                    r_res     <= w_res;
                    r_res_vld <= 1'b1;
                    r_acc     <= '0;
                    r_phase   <= '0;
                end else begin
                    r_acc   <= r_acc + ACC_W'(i_data_data);
                    r_phase <= r_phase + 1'b1;
                end
            end
        end
    end

    assign w_pop = ~w_fifo_empty & ~o_valid_stop & ~o_data_stop;

    fir_sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_res_vld),
        .i_pop   (w_pop),
        .i_din   (r_res),
        .o_dout  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign o_valid_valid = ~w_fifo_empty;
    assign o_data_valid  = ~w_fifo_empty;
    assign o_valid_data  = ~w_fifo_empty;
    assign o_data_data   = w_fifo_empty ? '0 : $signed(w_head);

endmodule

`default_nettype wire

// File: tb/tb_fir_decimator.sv
// ============================================================================
//  Module   : tb_fir_decimator
//  Brief    : Randomised and directed bench for fir_decimator against a
//             queue-based averaging model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_decimator;

    localparam int DECIM = 4;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               iv_v, iv_d, id_v;
    logic signed [15:0] id_d;
    logic               i_valid_stop, i_data_stop;
    logic               o_valid_valid, o_valid_data, o_data_valid;
    logic signed [15:0] o_data_data;
    logic               o_valid_stop, o_data_stop;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc = 0;
    int n_pop = 0;
    int cyc = 0;
    int acc4_cyc = -1;
    int first_out_cyc = -1;
    int smode = 0;
    int part[$];
    int expq[$];
    int e_val;
    int m_sum;

    always #5 clk = ~clk;

    fir_decimator #(.DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid_valid (iv_v),
        .i_valid_data  (iv_d),
        .i_valid_stop  (i_valid_stop),
        .i_data_valid  (id_v),
        .i_data_data   (id_d),
        .i_data_stop   (i_data_stop),
        .o_valid_valid (o_valid_valid),
        .o_valid_data  (o_valid_data),
        .o_valid_stop  (o_valid_stop),
        .o_data_valid  (o_data_valid),
        .o_data_data   (o_data_data),
        .o_data_stop   (o_data_stop)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mean of DECIM samples, rounded half-up (floor of (sum + DECIM/2) / DECIM).
    function automatic int model_avg(input int s);
        int t;
        int q;
        t = s + DECIM / 2;
        q = t / DECIM;
        if ((t % DECIM) != 0 && t < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    always @(negedge clk) begin
        case (smode)
            0: begin o_valid_stop = 1'b0; o_data_stop = 1'b0; end
            1: begin o_valid_stop = 1'b0; o_data_stop = 1'b1; end
            2: begin o_valid_stop = 1'b1; o_data_stop = 1'b0; end
            default: begin
                o_valid_stop = ($urandom % 4) == 0;
                o_data_stop  = ($urandom % 4) == 0;
            end
        endcase
    end

    // Scoreboard: observes handshakes on the rising edge, before DUT state moves.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            part.delete();
            expq.delete();
        end else begin
            if (iv_v && id_v && !i_valid_stop) begin
                n_acc++;
                if (iv_d) begin
                    part.push_back(int'(id_d));
                    if (part.size() == DECIM) begin
                        m_sum = 0;
                        foreach (part[k]) m_sum += part[k];
                        expq.push_back(model_avg(m_sum));
                        part.delete();
                        if (acc4_cyc < 0) acc4_cyc = cyc;
                    end
                end
            end
            if (o_valid_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (o_valid_valid && !o_valid_stop && !o_data_stop) begin
                n_pop++;
                chk("out_flag", int'(o_valid_data), 1);
                chk("out_dvalid", int'(o_data_valid), 1);
                e_val = (expq.size() > 0) ? expq.pop_front() : 32'h7fffffff;
                chk("out_data", int'(o_data_data), e_val);
            end
        end
    end

    task automatic idle();
        iv_v = 1'b0;
        id_v = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input bit f, input int v);
        int snap;
        int b;
        snap = n_acc;
        b = 0;
        iv_v = 1'b1;
        id_v = 1'b1;
        iv_d = f;
        id_d = 16'(v);
        do begin
            @(negedge clk);
            b++;
        end while (n_acc == snap && b < 500);
        if (n_acc == snap) chk("send_timeout", n_acc, snap + 1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((expq.size() > 0 || o_valid_valid) && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk("drain_q", expq.size(), 0);
        chk("drain_ovalid", int'(o_valid_valid), 0);
    endtask

    initial begin
        int p0;
        int snap;
        int pp;
        int h;
        int vals[12] = '{1, 2, 3, 4, -1, -2, -3, -4, 32767, 32767, 32767, 32767};

        reset = 1'b1;
        iv_d = 1'b0;
        id_d = '0;
        idle();
        repeat (3) @(negedge clk);
        iv_v = 1'b1;
        id_v = 1'b1;
        #1;
        chk("rst_vstop", int'(i_valid_stop), 1);
        chk("rst_dstop", int'(i_data_stop), 1);
        chk("rst_ovv", int'(o_valid_valid), 0);
        chk("rst_odv", int'(o_data_valid), 0);
        chk("rst_ovd", int'(o_valid_data), 0);
        chk("rst_odd", int'(o_data_data), 0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Constant input, latency of the first result
        acc4_cyc = -1;
        first_out_cyc = -1;
        p0 = n_pop;
        for (int i = 0; i < 8; i++) send(1'b1, 20000);
        idle();
        drain();
        chk("const_count", n_pop - p0, 2);
        chk("const_latency", first_out_cyc - acc4_cyc, 2);

        // Rounding and large values
        p0 = n_pop;
        for (int i = 0; i < 12; i++) send(1'b1, vals[i]);
        idle();
        drain();
        chk("round_count", n_pop - p0, 3);

        // Bubbles are discarded
        p0 = n_pop;
        send(1'b1, 1000); send(1'b0, 5555); send(1'b1, 1000);
        send(1'b1, 1000); send(1'b0, 5555); send(1'b1, 1000);
        idle();
        drain();
        chk("bubble_count", n_pop - p0, 1);

        // Join skew: data channel alone must not transfer
        snap = n_acc;
        iv_v = 1'b0;
        id_v = 1'b1;
        iv_d = 1'b1;
        id_d = 16'sd77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("skew_vstop", int'(i_valid_stop), 1);
            chk("skew_dstop", int'(i_data_stop), 1);
        end
        chk("skew_noacc", n_acc, snap);
        send(1'b1, 77);
        idle();
        chk("skew_one", n_acc, snap + 1);
        for (int i = 0; i < 3; i++) send(1'b1, 77);
        idle();
        drain();

        // Backpressure with output data stop held
        smode = 1;
        repeat (2) @(negedge clk);
        snap = n_acc;
        p0 = n_pop;
        fork
            begin
                for (int i = 1; i <= 40; i++) send(1'b1, i);
                idle();
            end
        join_none
        repeat (80) @(negedge clk);
        chk("bp_accepts", n_acc - snap, 32);
        chk("bp_istop", int'(i_valid_stop), 1);
        chk("bp_pops", n_pop - p0, 0);
        chk("bp_queued", expq.size(), 8);
        smode = 2;
        repeat (2) @(negedge clk);
        pp = n_pop;
        h = int'(o_data_data);
        repeat (6) @(negedge clk);
        chk("vstop_nopop", n_pop, pp);
        chk("vstop_head", int'(o_data_data), h);
        chk("vstop_ovalid", int'(o_valid_valid), 1);
        smode = 0;
        wait fork;
        drain();
        chk("bp_total", n_pop - p0, 10);

        // Reset mid-accumulation
        p0 = n_pop;
        send(1'b1, 500);
        send(1'b1, 500);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 100);
        idle();
        drain();
        chk("rstmid_count", n_pop - p0, 1);

        // Randomised traffic with random output stalls
        smode = 3;
        p0 = n_pop;
        snap = n_acc;
        for (int i = 0; i < 300; i++) begin
            if (($urandom % 5) == 0) begin
                idle();
                @(negedge clk);
            end
            send(($urandom % 4) != 0, int'($urandom_range(0, 65535)) - 32768);
        end
        idle();
        smode = 0;
        drain();
        chk("rand_accepts", n_acc - snap, 300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of `fir_cascade`. It consumes the filter's two latency-insensitive output channels, sample-validity and sample-data, as one joined token stream. It averages every DECIM flagged samples into one rounded 16-bit result and buffers results in a small FIFO. Results are presented on the same two-channel valid/data/stop interface to the next consumer, with full backpressure propagation.

## Interface
- DECIM, 4: decimation factor; power of two, 1..64; 1 = pass-through with buffering
- FIFO_DEPTH, 8: result FIFO entries; power of two, >= 2
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- i_valid_valid  in  1  validity channel: token present
- i_valid_data  in  1  validity channel: 1 = sample meaningful, 0 = bubble
- i_valid_stop  out  1  validity channel backpressure
- i_data_valid  in  1  data channel: token present
- i_data_data  in  16  data channel: signed sample
- i_data_stop  out  1  data channel backpressure
- o_valid_valid  out  1  output validity channel: token present
- o_valid_data  out  1  output validity flag; always 1 when o_valid_valid=1
- o_valid_stop  in  1  output validity channel backpressure
- o_data_valid  out  1  output data channel: token present
- o_data_data  out  16  signed decimated result
- o_data_stop  in  1  output data channel backpressure

## Operation
- Channel rule: a transfer occurs on an edge where valid=1 and stop=0. A producer holds valid and data stable while stop=1.
- Input join:
  - accept = i_valid_valid & i_data_valid & ~full_pend.
  - i_valid_stop = i_data_stop = ~accept. Both are combinational from the input valids.
  - Both channels always transfer together. If only one channel is valid, neither transfers and both stops are high.
- full_pend = (fifo_count + res_vld) >= FIFO_DEPTH. It counts the in-flight result register.
- On accept with i_valid_data=0, the token is consumed and discarded; accumulator state is unchanged.
- On accept with i_valid_data=1:
  - acc += sext(i_data_data), with acc signed 16+log2(DECIM) bits.
  - phase++.
  - When phase reaches DECIM-1:
    - res = sat16((acc + sample + DECIM/2) >>> log2(DECIM)). This is round-half-up, arithmetic shift.
    - res_vld <= 1, acc <= 0, phase <= 0.
- res_vld=1 pushes res into the FIFO on the next edge and clears res_vld, unless a new result is written the same edge.
- Output pop:
  - o_valid_valid = o_data_valid = ~empty.
  - o_data_data = FIFO head (first-word fall-through).
  - pop = ~empty & ~o_valid_stop & ~o_data_stop. Both channels pop together.
  - If only one output stop is high, neither channel transfers and the head is held.
- Simultaneous push and pop is allowed at any count, including full. Count is unchanged in that case.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - acc=0, phase=0, res_vld=0, FIFO empty.
  - o_valid_valid=0, o_data_valid=0, o_valid_data=0, o_data_data=0.
  - i_*_stop=1 while reset=1.
- Reset mid-accumulation discards the partial sum and phase. The first post-reset result uses only post-reset samples.
- Latency: the DECIM-th flagged sample accepted at edge t gives o_*_valid=1 after edge t+2, i.e. visible during cycle t+2.
- Throughput: one input token per cycle. One output per DECIM flagged samples.
- The stop path from output to input is registered through fifo_count, so it has no combinational path.
- Overflow is impossible by construction. Saturation is still required as a guard.

## Structure
- Shared package `fir_pkg`:
  - SAMPLE_W=16
  - `sample_t` (logic signed [15:0])
  - `sat16()` function, shared with `fir_cascade`
- Sub-module `fir_sync_fifo`:
  - parameterised width/depth, FWFT
  - ports: push, pop, din, dout, count, empty, full
- Top holds the join, the accumulator/phase counter, the result register and the output glue.

## Test plan
- Constant input, DECIM=4: eight flagged tokens of 20000, back-to-back, outputs unstalled -> two outputs of 20000; first o_*_valid two cycles after the 4th accept.
- Rounding: 1,2,3,4 -> 3. Then -1,-2,-3,-4 -> -2. Then 32767 x4 -> 32767.
- Bubbles: 1000 flagged, 5555 unflagged, 1000, 1000, 5555 unflagged, 1000 -> single output 1000.
- Join skew: i_data_valid=1 with i_valid_valid=0 for 3 cycles -> both stops high, no transfer. Then both valid -> exactly one token accepted.
- Backpressure, FIFO_DEPTH=8:
  - Hold o_data_stop=1 and feed 40 flagged tokens with values 1..40 -> input stops assert after 32 accepts, with 8 results stored.
  - Release o_data_stop -> results 3,7,11,...,39 in order, none lost or duplicated.
  - Assert only o_valid_stop -> no pop on either output channel.
- Reset mid-operation: accept 2 samples of 500, pulse reset one cycle, then feed 4 samples of 100 -> exactly one output, value 100, with no residue from before reset.
